// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline hazard controller.
//   stage_entry_t  : per-stage tracking record {valid, rd, reg_write, is_load}
//   fwd_sel_w()    : width of a forwarding-source select for a given depth
//   sat_inc32()    : saturating 32-bit increment for the performance counters
// Optional feature macro: PIPE_HAZARD_FWD_EN (forwarding selects + load-use stall).
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Register index field is sized for the widest supported register file;
    // narrower indices are zero-extended when they are stored.
    localparam int REG_AW_MAX = 8;

    // Default pipeline depth and the resulting forwarding-select width.
    localparam int DEPTH_DEF = 3;

    // First stage from which a load result can be forwarded; a load that is
    // still younger than this forces a one-cycle load-use stall.
    localparam int LOAD_DATA_STAGE = 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } stage_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FWD_SEL_W = fwd_sel_w(DEPTH_DEF);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the decode stage / pipeline (master) and the hazard
// controller (slave).
//   master drives : id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
//                   id_rd, id_reg_write, id_is_load, br_taken
//   slave drives  : stall, flush, wb_en, wb_rd, stall_cnt, flush_cnt
//                   and fwd_sel1 / fwd_sel2 when PIPE_HAZARD_FWD_EN is defined
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5
);
    localparam int FWD_W = pipe_pkg::fwd_sel_w(DEPTH);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              br_taken;

    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`ifdef PIPE_HAZARD_FWD_EN
    logic [FWD_W-1:0]  fwd_sel1;
    logic [FWD_W-1:0]  fwd_sel2;
`endif

    modport master (
`ifdef PIPE_HAZARD_FWD_EN
        input  fwd_sel1, fwd_sel2,
`endif
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load, br_taken,
        input  stall, flush, wb_en, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
`ifdef PIPE_HAZARD_FWD_EN
        output fwd_sel1, fwd_sel2,
`endif
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_is_load, br_taken,
        output stall, flush, wb_en, wb_rd, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational comparator of one ID source register against every in-flight
// stage entry.
//   id_valid, rs_used, rs : the source being checked
//   stages                : stage entries 1..DEPTH (1 = youngest)
//   hit                   : the source matches a writing, valid stage
//   hit_stage             : youngest matching stage (0 when no hit)
//   hit_is_load           : that youngest match is a load
// -----------------------------------------------------------------------------
module hazard_match
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int FWD_W  = 2
) (
    input  logic                     id_valid,
    input  logic                     rs_used,
    input  logic [REG_AW-1:0]        rs,
    input  stage_entry_t [DEPTH:1]   stages,
    output logic                     hit,
    output logic [FWD_W-1:0]         hit_stage,
    output logic                     hit_is_load
);

    logic [REG_AW_MAX-1:0] rs_ext;
    logic [DEPTH:1]        match;

    assign rs_ext = REG_AW_MAX'(rs);

    // x0 is hard-wired to zero, so it never creates a dependency.
    generate
        for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_cmp
            assign match[gi] = id_valid & rs_used & (rs != '0)
                             & stages[gi].valid & stages[gi].reg_write
                             & (stages[gi].rd == rs_ext);
        end
    endgenerate

    // Scan oldest to youngest so the last assignment is the youngest match,
    // which holds the most recent value of the register.
    always_comb begin
        hit         = |match;
        hit_stage   = '0;
        hit_is_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match[k]) begin
                hit_stage   = FWD_W'(k);
                hit_is_load = stages[k].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Data/control hazard controller for an in-order pipeline. Tracks the
// destination of every instruction in post-decode stages 1..DEPTH, stalls the
// ID instruction on a read-after-write dependency, flushes younger work on a
// taken branch resolved at BR_STAGE, and qualifies the writeback.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pipe_hazard_ctrl_if.slave (ID fields, br_taken in;
//                stall, flush, wb_en/wb_rd, counters out)
// Parameters: DEPTH (2..8), REG_AW (<= 8), BR_STAGE (1..DEPTH-1).
// Optional macro PIPE_HAZARD_FWD_EN: adds fwd_sel1/fwd_sel2 and restricts
// stalling to load-use cases the forwarding network cannot cover.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int FWD_W = fwd_sel_w(DEPTH);

    stage_entry_t [DEPTH:1] stg_reg;
    stage_entry_t [DEPTH:1] stg_next;
    stage_entry_t           id_entry;

    logic [31:0]      stall_cnt_reg;
    logic [31:0]      flush_cnt_reg;

    logic             flush_raw;
    logic             stall_raw;
    logic             flush_out;
    logic             stall_out;

    logic             m1_hit, m2_hit;
    logic [FWD_W-1:0] m1_stage, m2_stage;
    logic             m1_load, m2_load;

    // ------------------------------------------------------------------
    // Source comparators
    // ------------------------------------------------------------------
    hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_match_rs1 (
        .id_valid    (bus.id_valid),
        .rs_used     (bus.id_rs1_used),
        .rs          (bus.id_rs1),
        .stages      (stg_reg),
        .hit         (m1_hit),
        .hit_stage   (m1_stage),
        .hit_is_load (m1_load)
    );

    hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_match_rs2 (
        .id_valid    (bus.id_valid),
        .rs_used     (bus.id_rs2_used),
        .rs          (bus.id_rs2),
        .stages      (stg_reg),
        .hit         (m2_hit),
        .hit_stage   (m2_stage),
        .hit_is_load (m2_load)
    );

    // ------------------------------------------------------------------
    // Stall / flush decisions
    // ------------------------------------------------------------------
    assign flush_raw = bus.br_taken & stg_reg[BR_STAGE].valid;

`ifdef PIPE_HAZARD_FWD_EN
    // Everything is forwardable except a load that has not yet reached the
    // stage where its data becomes available.
    assign stall_raw = (m1_hit & m1_load & (m1_stage < FWD_W'(LOAD_DATA_STAGE)))
                     | (m2_hit & m2_load & (m2_stage < FWD_W'(LOAD_DATA_STAGE)));
    assign bus.fwd_sel1 = rst_n ? m1_stage : '0;
    assign bus.fwd_sel2 = rst_n ? m2_stage : '0;
`else
    assign stall_raw = m1_hit | m2_hit;

    // Youngest-match details only matter when forwarding is built in.
    logic unused_fwd_info;
    assign unused_fwd_info = ^{m1_stage, m1_load, m2_stage, m2_load};
`endif

    // Flush wins over stall: the stalled ID instruction is being killed anyway.
    // Both outputs are held low while reset is asserted.
    assign flush_out = rst_n & flush_raw;
    assign stall_out = rst_n & ~flush_raw & stall_raw;

    assign bus.flush = flush_out;
    assign bus.stall = stall_out;

    // ------------------------------------------------------------------
    // Stage advance
    // ------------------------------------------------------------------
    always_comb begin
        id_entry.valid     = bus.id_valid & ~stall_raw & ~flush_raw;
        id_entry.rd        = REG_AW_MAX'(bus.id_rd);
        id_entry.reg_write = bus.id_reg_write;
        id_entry.is_load   = bus.id_is_load;
    end

    // Instructions younger than the branch (stages 1..BR_STAGE-1) are
    // invalidated as they shift forward; the branch itself and older work
    // continue untouched.
    always_comb begin
        stg_next    = stg_reg;
        stg_next[1] = id_entry;
        for (int k = 2; k <= DEPTH; k++) begin
            stg_next[k] = stg_reg[k-1];
            if (flush_raw && ((k - 1) < BR_STAGE)) begin
                stg_next[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_reg       <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stg_reg       <= stg_next;
            stall_cnt_reg <= sat_inc32(stall_cnt_reg, stall_out);
            flush_cnt_reg <= sat_inc32(flush_cnt_reg, flush_out);
        end
    end

    // ------------------------------------------------------------------
    // Writeback qualification and counters
    // ------------------------------------------------------------------
    assign bus.wb_en = rst_n & stg_reg[DEPTH].valid & stg_reg[DEPTH].reg_write
                     & (stg_reg[DEPTH].rd != '0);
    assign bus.wb_rd = stg_reg[DEPTH].rd[REG_AW-1:0];

    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed, table-driven bench for pipe_hazard_ctrl (DEPTH=3, BR_STAGE=1).
// Each table row is one clock cycle: ID/branch inputs plus the expected
// combinational outputs and counter values seen before the next rising edge.
// Builds with or without PIPE_HAZARD_FWD_EN; each build runs its own table.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl_if #(.DEPTH(3), .REG_AW(5)) bus ();

    pipe_hazard_ctrl #(.DEPTH(3), .REG_AW(5), .BR_STAGE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst, vld, rs1, u1, rs2, u2, rd, rw, ld, br;
        int st, fl, wb, wrd;   // expected stall, flush, wb_en, wb_rd (wb_rd only when wb=1)
        int sc, fc;            // expected counters, negative = not checked
        int f1, f2;            // expected fwd selects (forwarding build only)
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input int rst, vld, rs1, u1, rs2, u2, rd, rw, ld, br,
                               input int st, fl, wb, wrd, sc, fc,
                               input int f1 = 0, input int f2 = 0);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.ld = ld; v.br = br;
        v.st = st; v.fl = fl; v.wb = wb; v.wrd = wrd; v.sc = sc; v.fc = fc;
        v.f1 = f1; v.f2 = f2;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n            = v.rst[0];
        bus.id_valid     = v.vld[0];
        bus.id_rs1       = 5'(v.rs1);
        bus.id_rs1_used  = v.u1[0];
        bus.id_rs2       = 5'(v.rs2);
        bus.id_rs2_used  = v.u2[0];
        bus.id_rd        = 5'(v.rd);
        bus.id_reg_write = v.rw[0];
        bus.id_is_load   = v.ld[0];
        bus.br_taken     = v.br[0];
    endtask

    // Drive after the falling edge, compare 1 time unit later, well before
    // the next rising edge.
    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        $display("vec %0d: stall=%0b flush=%0b wb_en=%0b wb_rd=%0d stall_cnt=%0h flush_cnt=%0h",
                 idx, bus.stall, bus.flush, bus.wb_en, bus.wb_rd, bus.stall_cnt, bus.flush_cnt);
        chk(idx, "stall", 32'(bus.stall), 32'(v.st));
        chk(idx, "flush", 32'(bus.flush), 32'(v.fl));
        chk(idx, "wb_en", 32'(bus.wb_en), 32'(v.wb));
        if (v.wb != 0) chk(idx, "wb_rd", 32'(bus.wb_rd), 32'(v.wrd));
        if (v.sc >= 0) chk(idx, "stall_cnt", bus.stall_cnt, 32'(v.sc));
        if (v.fc >= 0) chk(idx, "flush_cnt", bus.flush_cnt, 32'(v.fc));
`ifdef PIPE_HAZARD_FWD_EN
        chk(idx, "fwd_sel1", 32'(bus.fwd_sel1), 32'(v.f1));
        chk(idx, "fwd_sel2", 32'(bus.fwd_sel2), 32'(v.f2));
`endif
    endtask

    initial begin
        drive(V(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,-1,-1));

`ifdef PIPE_HAZARD_FWD_EN
        //           rst vld rs1 u1 rs2 u2 rd rw ld br  st fl wb wrd sc fc f1 f2
        tbl.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0, -1,-1, 0,0));
        tbl.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  0, 0, 0,0));
        tbl.push_back(V(1,1, 0,0, 0,0, 7,1,0,0,  0,0,0,0,  0, 0, 0,0)); // ALU rd=7
        tbl.push_back(V(1,1, 0,1, 7,1, 1,1,0,0,  0,0,0,0,  0, 0, 0,1)); // rs2=7 forwarded from stage 1
        tbl.push_back(V(1,1, 7,1, 1,1, 0,0,0,0,  0,0,0,0,  0, 0, 2,1)); // rs1 from stage 2, rs2 from stage 1
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,1,7,  0, 0, 0,0));
        tbl.push_back(V(1,1, 0,0, 0,0, 7,1,1,0,  0,0,1,1,  0, 0, 0,0)); // load rd=7
        tbl.push_back(V(1,1, 0,0, 7,1, 2,1,0,0,  1,0,0,0,  0, 0, 0,1)); // load-use stall
        tbl.push_back(V(1,1, 0,0, 7,1, 2,1,0,0,  0,0,0,0,  1, 0, 0,2)); // now forwarded from stage 2
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,1,7,  1, 0, 0,0));
`else
        //           rst vld rs1 u1 rs2 u2 rd rw ld br  st fl wb wrd sc fc
        tbl.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0, -1,-1));
        tbl.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  0, 0));
        tbl.push_back(V(1,1, 0,0, 0,0, 5,1,0,0,  0,0,0,0,  0, 0)); // write rd=5
        tbl.push_back(V(1,1, 5,1, 0,0, 6,1,0,0,  1,0,0,0,  0, 0)); // RAW on stage 1
        tbl.push_back(V(1,1, 5,1, 0,0, 6,1,0,0,  1,0,0,0,  1, 0)); // stage 2
        tbl.push_back(V(1,1, 5,1, 0,0, 6,1,0,0,  1,0,1,5,  2, 0)); // stage 3, writing back
        tbl.push_back(V(1,1, 5,1, 0,0, 6,1,0,0,  0,0,0,0,  3, 0)); // released
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 0));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 0));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,1,6,  3, 0));
        tbl.push_back(V(1,1, 0,0, 0,0, 0,1,0,0,  0,0,0,0,  3, 0)); // write to x0
        tbl.push_back(V(1,1, 0,1, 0,0, 2,1,0,0,  0,0,0,0,  3, 0)); // read x0: no hazard
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 0));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 0)); // x0 write suppressed
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,1,2,  3, 0));
        tbl.push_back(V(1,1, 0,0, 0,0, 9,1,0,0,  0,0,0,0,  3, 0)); // write rd=9
        tbl.push_back(V(1,1, 0,0, 9,0, 0,0,0,0,  0,0,0,0,  3, 0)); // rs2=9 not used
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 0));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,1,9,  3, 0));
        tbl.push_back(V(1,1, 0,0, 0,0, 4,1,0,0,  0,0,0,0,  3, 0)); // branch-like writer rd=4
        tbl.push_back(V(1,1, 4,1, 0,0, 8,1,0,1,  0,1,0,0,  3, 0)); // taken: flush beats stall
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 1));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,1,4,  3, 1));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 1)); // killed rd=8 never writes
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,1,  0,0,0,0,  3, 1)); // br_taken on a bubble
        tbl.push_back(V(1,1, 0,0, 0,0, 3,1,0,0,  0,0,0,0,  3, 1)); // write rd=3
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  3, 1));
        tbl.push_back(V(0,1, 3,1, 0,0, 0,0,0,0,  0,0,0,0,  3, 1)); // reset while rd=3 in stage 2
        tbl.push_back(V(1,1, 3,1, 0,0, 0,0,0,0,  0,0,0,0,  0, 0)); // entry discarded
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  0, 0));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  0, 0));
        tbl.push_back(V(1,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,  0, 0));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            apply(i, tbl[i]);
        end

`ifndef PIPE_HAZARD_FWD_EN
        // Counter saturation: preload one below the ceiling, then stall 3 times.
        @(negedge clk);
        force dut.stall_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_reg;
        chk(100, "stall_cnt_preload", bus.stall_cnt, 32'hFFFF_FFFE);
        apply(101, V(1,1, 0,0, 0,0, 5,1,0,0,  0,0,0,0, -1,-1));
        apply(102, V(1,1, 5,1, 0,0, 6,1,0,0,  1,0,0,0, -1,-1));
        apply(103, V(1,1, 5,1, 0,0, 6,1,0,0,  1,0,0,0, -1,-1));
        chk(103, "stall_cnt_ceiling", bus.stall_cnt, 32'hFFFF_FFFF);
        apply(104, V(1,1, 5,1, 0,0, 6,1,0,0,  1,0,1,5, -1,-1));
        apply(105, V(1,1, 5,1, 0,0, 6,1,0,0,  0,0,0,0, -1,-1));
        chk(105, "stall_cnt_saturated", bus.stall_cnt, 32'hFFFF_FFFF);
        chk(105, "flush_cnt_idle", bus.flush_cnt, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of post-decode stages up to and including writeback (2..8).
REQ-002 SHALL have parameter REG_AW, default 5, meaning the register index width.
REQ-003 SHALL have parameter BR_STAGE, default 1, meaning the stage (1..DEPTH-1) where the branch outcome resolves.
REQ-004 SHALL have port clk  in  1  system clock; the block uses this one clock only.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port id_valid  in  1  a decoded instruction is presented.
REQ-007 SHALL have ports id_rs1, id_rs2  in  REG_AW  source register indices.
REQ-008 SHALL have ports id_rs1_used, id_rs2_used  in  1  the corresponding source is actually read.
REQ-009 SHALL have ports id_rd  in  REG_AW, id_reg_write  in  1, id_is_load  in  1  giving the destination, the write intent and the load flag.
REQ-010 SHALL have port br_taken  in  1  the instruction in stage BR_STAGE redirects the PC.
REQ-011 SHALL have port stall  out  1  hold the PC and ID, and insert a bubble.
REQ-012 SHALL have port flush  out  1  kill the ID instruction and all younger in-flight instructions.
REQ-013 SHALL have ports wb_en  out  1 and wb_rd  out  REG_AW  giving the qualified register-file write.
REQ-014 SHALL have ports fwd_sel1, fwd_sel2  out  $clog2(DEPTH+1)  giving the forwarding source (0 = register file, k = stage k); these exist only with the macro.
REQ-015 SHALL have ports stall_cnt, flush_cnt  out  32  performance counters.

Function
REQ-016 SHALL keep per-stage entries {valid, rd, reg_write, is_load} for stages 1..DEPTH, and advance them every cycle.
REQ-017 SHALL load stage 1 with the ID entry (valid = id_valid & ~stall & ~flush), otherwise with a bubble (valid = 0).
REQ-018 SHALL assert flush combinationally when br_taken & stage[BR_STAGE].valid.
REQ-019 SHALL, on flush, clear valid in stages 1..BR_STAGE-1 at the next edge; the branch and older instructions proceed.
REQ-020 SHALL define a hazard on rsN as: id_valid & rsN_used & rsN != 0 & stage[k].valid & stage[k].reg_write & stage[k].rd == rsN, for some k in 1..DEPTH.
REQ-021 SHALL, without the macro, assert stall on any hazard.
REQ-022 SHALL force stall low while flush is high, because flush has priority.
REQ-023 SHALL drive wb_en = stage[DEPTH].valid & reg_write & (rd != 0), with wb_rd = stage[DEPTH].rd.
REQ-024 SHALL increment stall_cnt on each stall cycle and flush_cnt on each flush cycle, saturating at 0xFFFFFFFF with no wrap.

Reset
REQ-025 SHALL, while rst_n = 0 at an edge, clear all stage valid bits and both counters.
REQ-026 SHALL hold stall, flush and wb_en at 0 during and after reset until new entries arrive; fwd_sel resets to 0.
REQ-027 SHALL let a reset asserted mid-flush or mid-stall discard all in-flight entries, with no pending kill surviving.

Configuration
REQ-028 SHALL, when PIPE_HAZARD_FWD_EN is defined, select for each source the youngest matching stage (lowest k) on fwd_sel, or 0 if none matches.
REQ-029 SHALL, with PIPE_HAZARD_FWD_EN, assert stall only when the youngest match is stage 1 with is_load = 1 (load-use), or at stage 2 or above for loads whose data arrives only at DEPTH.
REQ-030 SHALL, without PIPE_HAZARD_FWD_EN, omit the fwd_sel ports and apply REQ-021.

Structure
REQ-031 SHALL place the stage-entry struct typedef and the fwd_sel width constant in shared package pipe_pkg.
REQ-032 SHALL use one sub-module, hazard_match, for the combinational source-versus-stage comparator, instantiated once per source.

Verification (DEPTH=3, BR_STAGE=1)
REQ-033 SHALL cover: after reset, id rd=5 write, then id rs1=5 used, no macro -> stall=1 for 3 cycles, then 0; stall_cnt=3.
REQ-034 SHALL cover: rs1=0 used with an in-flight rd=0 write -> stall=0 and wb_en=0 when that entry reaches stage 3.
REQ-035 SHALL cover: branch in stage 1 with br_taken=1 while ID holds a hazarding instruction -> flush=1, stall=0, the ID entry is not inserted, and flush_cnt=1.
REQ-036 SHALL cover: with the macro, ALU rd=7 then rs2=7 -> stall=0 and fwd_sel2=1; load rd=7 then rs2=7 -> stall=1 for one cycle, then fwd_sel2=2.
REQ-037 SHALL cover: rst_n=0 for one cycle while stage 2 holds a valid write -> wb_en stays 0 for the next 3 cycles.
REQ-038 SHALL cover: stall_cnt preloaded (via force) to 0xFFFFFFFE, then 3 stall cycles -> the counter reads 0xFFFFFFFF.
